mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage data-memory controller; produces the load data and the enable/clear that the MEM/WB pipeline register consumes.
- Runs a req/ack handshake with data memory.
- Stalls the pipeline for multi-cycle accesses.
- Performs byte/half/word lane alignment with sign or zero extension, and reports misaligned accesses and timeouts.

Parameters:
TIMEOUT, 255, max WAIT cycles before bus error; 0 disables timeout
CNT_W, 8, timeout counter width; must satisfy TIMEOUT < 2**CNT_W

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
MemRead  in  1  load in MEM stage
MemWrite  in  1  store in MEM stage
Size  in  2  00 byte, 01 half, 10 word, 11 treated as word
Unsigned  in  1  load zero-extends when 1, sign-extends when 0
Addr  in  32  byte address from ALU result
wData_i  in  32  store data (rt)
mem_req  out  1  memory request, held until ack
mem_we  out  1  write strobe, valid with mem_req
mem_addr  out  32  {Addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory completion, 1-cycle pulse
mem_rdata  in  32  read data, valid with mem_ack
rData  out  32  aligned/extended load data to MEM/WB
Stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
wb_En  out  1  MEM/WB enable
wb_Clr  out  1  MEM/WB clear (bubble)
Misaligned  out  1  alignment exception
BusErr  out  1  timeout error

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (synchronous, active-high) forces IDLE, counter 0, and all registered outputs 0. Reset in WAIT drops mem_req at that edge; a later ack is ignored.
- access = MemRead|MemWrite; MemRead has priority if both are set.
- mis = access & ((Size==01 & Addr[0]) | (Size[1] & Addr[1:0]!=0)).
- IDLE:
  - access & !mis: latch addr, we, be, wdata, Size, Unsigned, Addr[1:0]; go to WAIT.
  - mis: no transaction. Misaligned=1 combinationally for that cycle; stay in IDLE.
- WAIT:
  - mem_req=1 (Moore output from the latched registers). Counter increments each cycle.
  - mem_ack=1: capture aligned read data into rdata_q (reads only); go to RESP.
  - counter reaches TIMEOUT-1 with no ack: rdata_q=0, err_q=1; go to RESP.
  - ack wins over timeout in the same cycle.
- RESP:
  - rData=rdata_q. BusErr=err_q (1-cycle pulse). Go to IDLE unconditionally.
  - Counter and err_q clear on exit.
- mem_ack outside WAIT is ignored.
- Stall = (IDLE & access & !mis) | WAIT. Combinational, so the requesting instruction is held.
- In RESP, Stall=0: the pipeline advances and MEM/WB captures rData at the same edge.
- wb_En=1 always; wb_Clr = Stall | mis. Bubbles enter WB while stalled, so no duplicate register-file writes.
- rData = 0 outside RESP.
- Minimum access latency is 3 cycles (IDLE → WAIT with ack on first WAIT cycle → RESP).
- Lanes are little-endian; lane = Addr[1:0].
  - Byte: be = 1<<lane; wdata = {4{wData_i[7:0]}}.
  - Half: be = 0011 when Addr[1]=0, 1100 when Addr[1]=1; wdata = {2{wData_i[15:0]}}.
  - Word: be = 1111; wdata = wData_i.
- Load extract:
  - Byte: mem_rdata[8*lane+:8], extended per Unsigned.
  - Half: mem_rdata[16*Addr[1]+:16], extended per Unsigned.
  - Word: mem_rdata unchanged.
- Stores return rData=0 in RESP.
- Back-to-back accesses: RESP → IDLE, then the next access starts one cycle later.

Decomposition:
- Package mem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD codes.
  - State encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Byte-enable lookup function.
- Sub-module mem_load_align: combinational lane select plus sign/zero extend. Inputs rdata, lane, size, unsigned; output data. Reused by any future cache read path.

Test Plan:
- Load word Addr=0x100, ack on 1st WAIT cycle, rdata=0xDEADBEEF → mem_addr=0x100, be=1111, Stall high 2 cycles, rData=0xDEADBEEF in RESP, wb_Clr high 2 cycles.
- Signed load byte Addr=0x103, rdata=0x80FF1234 → be=1000, rData=0xFFFFFF80. Same access with Unsigned=1 → rData=0x00000080.
- Store half Addr=0x202, wData_i=0x0000ABCD, ack after 4 WAIT cycles → mem_we=1, be=1100, wdata=0xABCDABCD, Stall high 5 cycles, rData=0.
- Load word Addr=0x101 → mem_req stays 0, Misaligned=1 and wb_Clr=1 for 1 cycle, Stall=0.
- TIMEOUT=4, no ack → mem_req high 4 cycles, then BusErr=1 and rData=0 in RESP, state returns to IDLE.
- rst=1 during WAIT, followed by a stray ack → mem_req=0 after the edge, Stall=0, ack ignored, no RESP.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared size codes, FSM encoding and byte-enable lookup for the MEM-stage controller
package mem_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;
  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] lane);
    return size == SIZE_BYTE ? 4'b0001 << lane :
           size == SIZE_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed byte/half of a little-endian word and sign/zero extends it
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane select then extension; size code 11 falls through to word
  always_comb begin
    b    = 8'(rdata >> {lane, 3'b000});
    h    = lane[1] ? rdata[31:16] : rdata[15:0];
    data = size == SIZE_BYTE ? {{24{~uns & b[7]}}, b} :
           size == SIZE_HALF ? {{16{~uns & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory req/ack controller with pipeline stall, lane alignment and error reporting
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] wData_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rData,
  output logic        Stall,
  output logic        wb_En,
  output logic        wb_Clr,
  output logic        Misaligned,
  output logic        BusErr
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [29:0] addr_q, addr_d;
  logic we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [3:0] be_q, be_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, ld_data;
  logic [1:0] size_q, size_d, lane_q, lane_d;
  logic access, mis, start, tmo;
  mem_load_align u_align (
    .rdata(mem_rdata),
    .lane (lane_q),
    .size (size_q),
    .uns  (uns_q),
    .data (ld_data)
  );
  // request decode: misalignment, transaction launch and timeout expiry
  always_comb begin
    access = MemRead | MemWrite;
    mis    = access & ((Size == SIZE_HALF & Addr[0]) | (Size[1] & Addr[1:0] != 2'b00));
    start  = state_q == IDLE & access & ~mis;
    tmo    = (TIMEOUT != 0) && cnt_q == CNT_W'(TIMEOUT - 1);
  end
  // state register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      lane_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // next state: ack and timeout both end WAIT; RESP always returns to IDLE
  always_comb begin
    state_d = state_q == IDLE ? (start ? WAIT : IDLE) :
              state_q == WAIT ? ((mem_ack | tmo) ? RESP : WAIT) : IDLE;
  end
  // latch the request on launch; capture load data on ack, flag error on timeout (ack wins)
  always_comb begin
    addr_d  = start ? Addr[31:2] : addr_q;
    we_d    = start ? ~MemRead : we_q;
    be_d    = start ? be_of(Size, Addr[1:0]) : be_q;
    wdata_d = start ? (Size == SIZE_BYTE ? {4{wData_i[7:0]}} :
                       Size == SIZE_HALF ? {2{wData_i[15:0]}} : wData_i) : wdata_q;
    size_d  = start ? Size : size_q;
    lane_d  = start ? Addr[1:0] : lane_q;
    uns_d   = start ? Unsigned : uns_q;
    cnt_d   = state_q == WAIT ? cnt_q + CNT_W'(1) : '0;
    rdata_d = (state_q == WAIT & mem_ack & ~we_q) ? ld_data : '0;
    err_d   = state_q == WAIT & ~mem_ack & tmo;
  end
  // outputs: memory bus is Moore from latched registers, pipeline controls are combinational
  always_comb begin
    mem_req    = state_q == WAIT;
    mem_we     = mem_req & we_q;
    mem_addr   = {addr_q, 2'b00};
    mem_be     = be_q;
    mem_wdata  = wdata_q;
    rData      = state_q == RESP ? rdata_q : '0;
    BusErr     = state_q == RESP & err_q;
    Stall      = start | state_q == WAIT;
    wb_En      = 1'b1;
    wb_Clr     = Stall | mis;
    Misaligned = state_q == IDLE & mis;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven and directed checks of the MEM-stage memory controller
module tb_mem_access_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic MemRead = 0, MemWrite = 0, Unsigned = 0, mem_ack = 0;
  logic [1:0] Size = 0;
  logic [31:0] Addr = 0, wData_i = 0, mem_rdata = 0;
  logic mem_req, mem_we, Stall, wb_En, wb_Clr, Misaligned, BusErr;
  logic [31:0] mem_addr, mem_wdata, rData;
  logic [3:0] mem_be;
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size),
    .Unsigned(Unsigned), .Addr(Addr), .wData_i(wData_i), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rData(rData), .Stall(Stall),
    .wb_En(wb_En), .wb_Clr(wb_Clr), .Misaligned(Misaligned), .BusErr(BusErr)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdat;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic        we;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    MemRead = v.rd; MemWrite = v.wr; Size = v.size; Unsigned = v.uns;
    Addr = v.addr; wData_i = v.wd; mem_ack = 0;
    #1;
    chk($sformatf("v%0d idle_stall", i), 32'(Stall), 1);
    chk($sformatf("v%0d idle_clr", i), 32'(wb_Clr), 1);
    chk($sformatf("v%0d idle_req", i), 32'(mem_req), 0);
    @(negedge clk);
    chk($sformatf("v%0d req", i), 32'(mem_req), 1);
    chk($sformatf("v%0d addr", i), mem_addr, {v.addr[31:2], 2'b00});
    chk($sformatf("v%0d be", i), 32'(mem_be), 32'(v.be));
    chk($sformatf("v%0d wdata", i), mem_wdata, v.mwd);
    chk($sformatf("v%0d we", i), 32'(mem_we), 32'(v.we));
    mem_ack = 1; mem_rdata = v.rdat;
    #1;
    chk($sformatf("v%0d wait_stall", i), 32'(Stall), 1);
    @(negedge clk);
    mem_ack = 0;
    #1;
    chk($sformatf("v%0d rdata", i), rData, v.exp);
    chk($sformatf("v%0d resp_stall", i), 32'(Stall), 0);
    chk($sformatf("v%0d resp_clr", i), 32'(wb_Clr), 0);
    chk($sformatf("v%0d resp_buserr", i), 32'(BusErr), 0);
    MemRead = 0; MemWrite = 0;
    @(negedge clk);
    chk($sformatf("v%0d back_idle_req", i), 32'(mem_req), 0);
    chk($sformatf("v%0d back_idle_rdata", i), rData, 0);
  endtask

  initial begin
    int stalls, n;
    vecs[0]  = '{1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 4'b1111, 0, 0, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 2'b00, 0, 32'h103, 0, 32'h80FF1234, 4'b1000, 0, 0, 32'hFFFFFF80};
    vecs[2]  = '{1, 0, 2'b00, 1, 32'h103, 0, 32'h80FF1234, 4'b1000, 0, 0, 32'h00000080};
    vecs[3]  = '{1, 0, 2'b01, 0, 32'h102, 0, 32'h80FF1234, 4'b1100, 0, 0, 32'hFFFF80FF};
    vecs[4]  = '{1, 0, 2'b01, 1, 32'h100, 0, 32'h80FF1234, 4'b0011, 0, 0, 32'h00001234};
    vecs[5]  = '{1, 0, 2'b00, 0, 32'h101, 0, 32'h80FF1234, 4'b0010, 0, 0, 32'h00000012};
    vecs[6]  = '{1, 0, 2'b00, 0, 32'h102, 0, 32'h007F8000, 4'b0100, 0, 0, 32'h0000007F};
    vecs[7]  = '{0, 1, 2'b00, 0, 32'h301, 32'h000000A5, 32'h11111111, 4'b0010, 32'hA5A5A5A5, 1, 0};
    vecs[8]  = '{0, 1, 2'b10, 0, 32'h400, 32'h12345678, 32'hCAFEF00D, 4'b1111, 32'h12345678, 1, 0};
    vecs[9]  = '{1, 0, 2'b11, 0, 32'h104, 0, 32'h01020304, 4'b1111, 0, 0, 32'h01020304};
    vecs[10] = '{1, 1, 2'b10, 0, 32'h108, 0, 32'h55AA55AA, 4'b1111, 0, 0, 32'h55AA55AA};

    repeat (3) @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_stall", 32'(Stall), 0);
    chk("rst_rdata", rData, 0);
    chk("rst_buserr", 32'(BusErr), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_wben", 32'(wb_En), 1);
    rst = 0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // store half, ack on the 4th WAIT cycle (same cycle the timeout would fire)
    stalls = 0;
    @(negedge clk);
    MemWrite = 1; Size = 2'b01; Addr = 32'h202; wData_i = 32'h0000ABCD;
    #1 stalls += int'(Stall);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack = (i == 3);
      #1 stalls += int'(Stall);
      if (i == 0) begin
        chk("sh we", 32'(mem_we), 1);
        chk("sh be", 32'(mem_be), 32'hC);
        chk("sh wdata", mem_wdata, 32'hABCDABCD);
        chk("sh addr", mem_addr, 32'h200);
      end
    end
    @(negedge clk);
    mem_ack = 0;
    #1;
    chk("sh resp_rdata", rData, 0);
    chk("sh resp_buserr", 32'(BusErr), 0);
    chk("sh resp_stall", 32'(Stall), 0);
    chk("sh stall_cycles", 32'(stalls), 5);
    MemWrite = 0;
    @(negedge clk);
    chk("sh idle_req", 32'(mem_req), 0);

    // misaligned word and half loads
    @(negedge clk);
    MemRead = 1; Size = 2'b10; Addr = 32'h101;
    #1;
    chk("mis_w flag", 32'(Misaligned), 1);
    chk("mis_w clr", 32'(wb_Clr), 1);
    chk("mis_w stall", 32'(Stall), 0);
    Size = 2'b01; Addr = 32'h103;
    #1;
    chk("mis_h flag", 32'(Misaligned), 1);
    @(negedge clk);
    chk("mis req", 32'(mem_req), 0);
    MemRead = 0;
    #1;
    chk("mis clear", 32'(Misaligned), 0);

    // timeout with no ack
    @(negedge clk);
    MemRead = 1; Size = 2'b10; Addr = 32'h500;
    @(negedge clk);
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("tmo req_cycles", 32'(n), 4);
    chk("tmo buserr", 32'(BusErr), 1);
    chk("tmo rdata", rData, 0);
    MemRead = 0;
    @(negedge clk);
    chk("tmo buserr_pulse", 32'(BusErr), 0);
    chk("tmo idle_req", 32'(mem_req), 0);

    // reset during WAIT followed by a stray ack
    @(negedge clk);
    MemRead = 1; Size = 2'b10; Addr = 32'h600;
    @(negedge clk);
    chk("rstw in_wait", 32'(mem_req), 1);
    rst = 1; MemRead = 0;
    @(negedge clk);
    chk("rstw req", 32'(mem_req), 0);
    chk("rstw stall", 32'(Stall), 0);
    rst = 0; mem_ack = 1; mem_rdata = 32'h99999999;
    @(negedge clk);
    mem_ack = 0;
    #1;
    chk("rstw no_resp_rdata", rData, 0);
    chk("rstw no_req", 32'(mem_req), 0);
    chk("rstw no_buserr", 32'(BusErr), 0);
    @(negedge clk);
    chk("rstw still_idle", rData, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
